noc_local_if: RTL and testbench

Network interface between a local core and the Local (L) port of a NoC router. On the transmit side it packs core words into flits and injects them with the router's 4-phase req/ack handshake. On the receive side it accepts flits ejected by the router on the same handshake and presents them to the core as a valid/ready stream. Each direction has its own FIFO, so the core is decoupled from router arbitration latency.

---
 rtl/noc_local_if.sv | 213 +++++++++++++++++++++
 tb/tb_noc_local_if.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_if.sv
// Core-side network interface for a NoC router L port: TX/RX FIFOs bridged to 4-phase req/ack.
// Optional destination check on received flits is enabled by defining NOC_IF_DEST_CHECK_EN.
module noc_local_if #(
  parameter logic [3:0]  POSITION   = 4'b0101,
  parameter int unsigned DATA_WIDTH = 37,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // core -> NoC stream
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-6:0] tx_payload,
  input  logic [3:0]            tx_dest,
  input  logic                  tx_last,
  // router L input port
  output logic [DATA_WIDTH-1:0] noc_out_data,
  output logic                  noc_out_req,
  input  logic                  noc_out_ack,
  // router L output port
  input  logic [DATA_WIDTH-1:0] noc_in_data,
  input  logic                  noc_in_req,
  output logic                  noc_in_ack,
  // NoC -> core stream
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-6:0] rx_payload,
  output logic [3:0]            rx_dest,
  output logic                  rx_last,
  output logic [7:0]            err_cnt
);

  localparam int unsigned ENTRIES = 2 ** FIFO_DEPTH;
  localparam int unsigned CW      = FIFO_DEPTH + 1;
  localparam int unsigned PW      = DATA_WIDTH - 5;

`ifdef NOC_IF_DEST_CHECK_EN
  localparam bit DEST_CHECK = 1'b1;
`else
  localparam bit DEST_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_t;
  typedef enum logic       {R_IDLE, R_ACK}        rx_state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_WIDTH-1:0] tx_mem [ENTRIES];
  logic [FIFO_DEPTH-1:0] tx_wr;
  logic [FIFO_DEPTH-1:0] tx_rd;
  logic [CW-1:0]         tx_cnt;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_empty;
  tx_state_t             tx_state;

  assign tx_ready = (tx_cnt != CW'(ENTRIES));
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = tx_valid && tx_ready;
  // Pop coincides with loading the head flit into the output register.
  assign tx_pop   = (tx_state == T_IDLE) && !tx_empty && !noc_out_ack;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr] <= {tx_payload, tx_last, tx_dest};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_wr <= tx_wr + FIFO_DEPTH'(1);
      end
      if (tx_pop) begin
        tx_rd <= tx_rd + FIFO_DEPTH'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state     <= T_IDLE;
      noc_out_req  <= 1'b0;
      noc_out_data <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (tx_pop) begin
            noc_out_data <= tx_mem[tx_rd];
            noc_out_req  <= 1'b1;
            tx_state     <= T_REQ;
          end
        end
        T_REQ: begin
          if (noc_out_ack) begin
            noc_out_req <= 1'b0;
            tx_state    <= T_REL;
          end
        end
        T_REL: begin
          if (!noc_out_ack) begin
            tx_state <= T_IDLE;
          end
        end
        default: begin
          noc_out_req <= 1'b0;
          tx_state    <= T_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_WIDTH-1:0] rx_mem [ENTRIES];
  logic [FIFO_DEPTH-1:0] rx_wr;
  logic [FIFO_DEPTH-1:0] rx_rd;
  logic [CW-1:0]         rx_cnt;
  logic                  rx_full;
  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_take;
  logic                  misroute;
  logic [DATA_WIDTH-1:0] rx_head;
  rx_state_t             rx_state;

  assign rx_full  = (rx_cnt == CW'(ENTRIES));
  assign rx_valid = (rx_cnt != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign misroute = DEST_CHECK && (noc_in_data[3:0] != POSITION);
  // Misrouted flits are always accepted (and dropped) so they never stall the router.
  assign rx_take  = (rx_state == R_IDLE) && noc_in_req && (misroute || !rx_full);
  assign rx_push  = rx_take && !misroute;

  assign rx_head    = rx_mem[rx_rd];
  assign rx_payload = rx_valid ? rx_head[DATA_WIDTH-1:5] : PW'(0);
  assign rx_last    = rx_valid ? rx_head[4] : 1'b0;
  assign rx_dest    = rx_valid ? rx_head[3:0] : 4'b0000;

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr] <= noc_in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_wr <= rx_wr + FIFO_DEPTH'(1);
      end
      if (rx_pop) begin
        rx_rd <= rx_rd + FIFO_DEPTH'(1);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= R_IDLE;
      noc_in_ack <= 1'b0;
      err_cnt    <= 8'h00;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (rx_take) begin
            noc_in_ack <= 1'b1;
            rx_state   <= R_ACK;
            if (misroute && (err_cnt != 8'hFF)) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        R_ACK: begin
          if (!noc_in_req) begin
            noc_in_ack <= 1'b0;
            rx_state   <= R_IDLE;
          end
        end
        default: begin
          noc_in_ack <= 1'b0;
          rx_state   <= R_IDLE;
        end
      endcase
    end
  end

  // Handshake invariants towards the router.
  a_no_req_while_ack: assert property (@(posedge clk) disable iff (!reset_n)
    (noc_out_ack && !noc_out_req) |=> !noc_out_req);
  a_no_ack_in_idle: assert property (@(posedge clk) disable iff (!reset_n)
    (rx_state == R_IDLE) |-> !noc_in_ack);
  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
    (tx_cnt <= CW'(ENTRIES)) && (rx_cnt <= CW'(ENTRIES)));

endmodule

// File: tb/tb_noc_local_if.sv
// Directed self-checking bench for noc_local_if with simple router and core models.
module tb_noc_local_if;

  localparam int unsigned DW  = 37;
  localparam logic [3:0]  POS = 4'b0101;

  logic          clk;
  logic          reset_n;
  logic          tx_valid;
  logic          tx_ready;
  logic [31:0]   tx_payload;
  logic [3:0]    tx_dest;
  logic          tx_last;
  logic [DW-1:0] noc_out_data;
  logic          noc_out_req;
  logic          noc_out_ack;
  logic [DW-1:0] noc_in_data;
  logic          noc_in_req;
  logic          noc_in_ack;
  logic          rx_valid;
  logic          rx_ready;
  logic [31:0]   rx_payload;
  logic [3:0]    rx_dest;
  logic          rx_last;
  logic [7:0]    err_cnt;

  noc_local_if #(.POSITION(POS), .DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_payload(tx_payload),
    .tx_dest(tx_dest), .tx_last(tx_last),
    .noc_out_data(noc_out_data), .noc_out_req(noc_out_req), .noc_out_ack(noc_out_ack),
    .noc_in_data(noc_in_data), .noc_in_req(noc_in_req), .noc_in_ack(noc_in_ack),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_payload(rx_payload),
    .rx_dest(rx_dest), .rx_last(rx_last), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] p, input logic l, input logic [3:0] d);
    return {p, l, d};
  endfunction

  // Router input-port model: acks 2 sampled cycles after req, records accepted flits.
  logic          tx_hold = 1'b1;
  int            req_hi_cycles = 0;
  int            ack_dly = 0;
  logic [DW-1:0] tx_got [$];

  initial begin
    noc_out_ack = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!reset_n) begin
        noc_out_ack = 1'b0;
      end else if (!tx_hold) begin
        if (noc_out_req) req_hi_cycles++;
        if (noc_out_req && !noc_out_ack) begin
          ack_dly++;
          if (ack_dly >= 2) begin
            noc_out_ack = 1'b1;
            tx_got.push_back(noc_out_data);
            ack_dly = 0;
          end
        end else if (!noc_out_req && noc_out_ack) begin
          noc_out_ack = 1'b0;
        end
      end
    end
  end

  // Router output-port model: offers rx_flits[rx_idx .. rx_total-1] in order.
  logic [DW-1:0] rx_flits [512];
  int            rx_total = 0;
  int            rx_idx = 0;
  int            rx_acks = 0;

  initial begin
    noc_in_req  = 1'b0;
    noc_in_data = '0;
    forever begin
      @(negedge clk); #1;
      if (noc_in_req && noc_in_ack) begin
        noc_in_req = 1'b0;
        rx_acks++;
      end else if (!noc_in_req && !noc_in_ack && rx_idx < rx_total) begin
        noc_in_data = rx_flits[rx_idx];
        rx_idx++;
        noc_in_req = 1'b1;
      end
    end
  end

  // Core RX consumer: mode 0 stalls, 1 always ready, 2 random ready.
  int            rx_mode = 0;
  logic [DW-1:0] rx_got [$];

  initial begin
    rx_ready = 1'b0;
    forever begin
      @(negedge clk); #1;
      case (rx_mode)
        1:       rx_ready = 1'b1;
        2:       rx_ready = 1'($urandom_range(0, 1));
        default: rx_ready = 1'b0;
      endcase
      if (rx_ready && rx_valid) rx_got.push_back({rx_payload, rx_last, rx_dest});
    end
  end

  task automatic push(input logic [DW-1:0] f);
    int guard = 0;
    while (!tx_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!tx_ready) check("push_timeout", tx_ready, 1'b1);
    {tx_payload, tx_last, tx_dest} = f;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int g = 0;
    while (tx_got.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("tx_count", tx_got.size(), n);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int g = 0;
    while (rx_got.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("rx_count", rx_got.size(), n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int hi0;
    int ack0;
    int g;
    logic [DW-1:0] bad;

    reset_n    = 1'b0;
    tx_valid   = 1'b0;
    tx_payload = '0;
    tx_dest    = '0;
    tx_last    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_out_req", noc_out_req, 1'b0);
    check("rst_in_ack", noc_in_ack, 1'b0);
    check("rst_out_data", noc_out_data, '0);
    check("rst_err_cnt", err_cnt, 8'h00);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Req latency, then asynchronous reset mid-handshake
    push(mk(32'h12345678, 1'b0, 4'b0011));
    check("req_not_yet", noc_out_req, 1'b0);
    @(negedge clk);
    check("req_rise", noc_out_req, 1'b1);
    check("req_data", noc_out_data, mk(32'h12345678, 1'b0, 4'b0011));
    #2 reset_n = 1'b0;
    #1;
    check("async_req_low", noc_out_req, 1'b0);
    check("async_ack_low", noc_in_ack, 1'b0);
    check("async_data_clr", noc_out_data, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tx_hold = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_req", noc_out_req, 1'b0);
    check("post_rst_tx_ready", tx_ready, 1'b1);
    check("post_rst_rx_valid", rx_valid, 1'b0);

    // Single TX flit
    base = tx_got.size();
    hi0  = req_hi_cycles;
    push(mk(32'hDEADBEEF, 1'b1, 4'b0110));
    wait_tx(base + 1, 20);
    check("single_out_data", noc_out_data, 37'h1BD5B7DDF6);
    check("single_got", tx_got[base], 37'h1BD5B7DDF6);
    repeat (4) @(negedge clk);
    check("single_req_cycles", req_hi_cycles - hi0, 2);
    check("single_req_low", noc_out_req, 1'b0);
    check("single_data_hold", noc_out_data, 37'h1BD5B7DDF6);
    check("single_one_trip", tx_got.size(), base + 1);

    // TX full: first flit waits in the output register, four more fill the FIFO
    tx_hold = 1'b1;
    base = tx_got.size();
    for (int i = 0; i < 5; i++) begin
      push(mk(32'h51000000 + 32'(i), 1'(i == 4), 4'(i + 1)));
      if (i == 3) check("tx_ready_after_4", tx_ready, 1'b1);
    end
    check("tx_full", tx_ready, 1'b0);
    check("tx_full_req", noc_out_req, 1'b1);
    bad = mk(32'hBADBAD00, 1'b0, 4'b1111);
    {tx_payload, tx_last, tx_dest} = bad;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_hold = 1'b0;
    g = 0;
    while (!tx_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("tx_ready_again", tx_ready, 1'b1);
    check("tx_first_pop_count", tx_got.size() - base, 1);
    wait_tx(base + 5, 60);
    for (int i = 0; i < 5; i++) begin
      if (tx_got.size() > base + i)
        check("tx_full_order", tx_got[base+i], mk(32'h51000000 + 32'(i), 1'(i == 4), 4'(i + 1)));
    end
    repeat (10) @(negedge clk);
    check("tx_no_extra", tx_got.size(), base + 5);

    // RX back-pressure: 5 offered with rx_ready low
    rx_mode = 0;
    ack0 = rx_acks;
    base = rx_got.size();
    for (int i = 0; i < 5; i++) rx_flits[rx_total+i] = mk(32'hA0000000 + 32'(i), 1'(i == 4), POS);
    rx_total += 5;
    repeat (30) @(negedge clk);
    check("rx_bp_acks", rx_acks - ack0, 4);
    check("rx_bp_valid", rx_valid, 1'b1);
    check("rx_bp_req", noc_in_req, 1'b1);
    check("rx_bp_ack", noc_in_ack, 1'b0);
    check("rx_head_payload", rx_payload, 32'hA0000000);
    check("rx_head_dest", rx_dest, POS);
    check("rx_head_last", rx_last, 1'b0);
    rx_mode = 1;
    @(negedge clk);
    rx_mode = 0;
    check("rx_ack_wait", noc_in_ack, 1'b0);
    @(negedge clk);
    check("rx_ack_after_pop", noc_in_ack, 1'b1);
    rx_mode = 1;
    wait_rx(base + 5, 60);
    for (int i = 0; i < 5; i++) begin
      if (rx_got.size() > base + i)
        check("rx_bp_order", rx_got[base+i], mk(32'hA0000000 + 32'(i), 1'(i == 4), POS));
    end
    rx_mode = 0;
    @(negedge clk);
    check("rx_empty_valid", rx_valid, 1'b0);
    check("rx_empty_payload", rx_payload, 32'h0);
    check("rx_empty_dest", rx_dest, 4'h0);

    // Simultaneous TX and RX streams of 8 flits each
    rx_mode = 2;
    base = rx_got.size();
    hi0  = tx_got.size();
    for (int i = 0; i < 8; i++) rx_flits[rx_total+i] = mk(32'hB0B00000 + 32'(i), 1'(i == 7), POS);
    rx_total += 8;
    for (int i = 0; i < 8; i++) push(mk(32'hC0DE0000 + 32'(i), 1'(i == 7), 4'(i)));
    g = 0;
    while ((tx_got.size() < hi0 + 8 || rx_got.size() < base + 8) && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("sim_tx_count", tx_got.size(), hi0 + 8);
    check("sim_rx_count", rx_got.size(), base + 8);
    for (int i = 0; i < 8; i++) begin
      if (tx_got.size() > hi0 + i)
        check("sim_tx_order", tx_got[hi0+i], mk(32'hC0DE0000 + 32'(i), 1'(i == 7), 4'(i)));
      if (rx_got.size() > base + i)
        check("sim_rx_order", rx_got[base+i], mk(32'hB0B00000 + 32'(i), 1'(i == 7), POS));
    end
    rx_mode = 0;
    repeat (4) @(negedge clk);

    // Flit addressed to another node
    ack0 = rx_acks;
    bad  = mk(32'h0BAD0000, 1'b1, 4'b0000);
    rx_flits[rx_total] = bad;
    rx_total += 1;
    repeat (6) @(negedge clk);
    check("dest_acked", rx_acks - ack0, 1);
`ifdef NOC_IF_DEST_CHECK_EN
    check("dest_dropped", rx_valid, 1'b0);
    check("dest_err_1", err_cnt, 8'd1);
    for (int i = 0; i < 299; i++) rx_flits[rx_total+i] = bad;
    rx_total += 299;
    g = 0;
    while ((rx_idx < rx_total || noc_in_req || noc_in_ack) && g < 1500) begin
      @(negedge clk);
      g++;
    end
    check("dest_all_acked", rx_acks - ack0, 300);
    check("dest_err_sat", err_cnt, 8'd255);
    check("dest_still_empty", rx_valid, 1'b0);
`else
    check("dest_stored", rx_valid, 1'b1);
    check("dest_field", rx_dest, 4'b0000);
    check("dest_err_zero", err_cnt, 8'd0);
    base = rx_got.size();
    rx_mode = 1;
    wait_rx(base + 1, 10);
    rx_mode = 0;
    if (rx_got.size() > base) check("dest_payload", rx_got[base], bad);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
